// File: rtl/pipe_mux_n.sv
// pipe_mux_n: N-way operand select feeding a 2-entry skid buffer
// with registered valid/ready output, flush and async reset.
//
// Ports:
//   clk, rst         clock, async active-high reset
//   flush            synchronous discard of buffered beats
//   in_data/in_sel   NSRC packed candidates and select code
//   in_valid/ready   producer handshake (in_ready registered)
//   out_data/out_sel selected word and its select code
//   out_valid/ready  consumer handshake
//   occupancy        beats held (0..2)
//   sel_err          out-of-range select flag, only when
//                    PIPE_MUX_SELERR_EN is defined
module pipe_mux_n #(
  parameter int WIDTH = 32,
  parameter int NSRC  = 4,
  parameter int SELW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [NSRC*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]       in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
`ifdef PIPE_MUX_SELERR_EN
  ,
  output logic                  sel_err
`endif
);

  generate
    if ((2 ** SELW) < NSRC) begin : g_bad_selw
      $error("pipe_mux_n: SELW too narrow for NSRC");
    end
    if (NSRC < 2) begin : g_bad_nsrc
      $error("pipe_mux_n: NSRC must be at least 2");
    end
  endgenerate

  // encoding doubles as the occupancy count
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_nstate;

  logic [WIDTH-1:0] r_m_data;
  logic [SELW-1:0]  r_m_sel;
  logic [WIDTH-1:0] r_s_data;
  logic [SELW-1:0]  r_s_sel;

  logic [WIDTH-1:0] w_word;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_ld_m;
  logic             w_m_from_s;
  logic             w_ld_s;
  logic             w_in_ready;
  logic             w_out_valid;

  // select resolved at input time; unmatched codes give zero
  always_comb begin
    w_word = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SELW'(k)) begin
        w_word = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  assign w_in_ready  = (r_state != TWO);
  assign w_out_valid = (r_state != EMPTY);
  assign w_in_xfer   = in_valid & w_in_ready;
  assign w_out_xfer  = w_out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate   = r_state;
    w_ld_m     = 1'b0;
    w_m_from_s = 1'b0;
    w_ld_s     = 1'b0;
    if (flush) begin
      w_nstate = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_ld_m   = 1'b1;
            w_nstate = ONE;
          end
        end
        ONE: begin
          if (w_out_xfer && w_in_xfer) begin
            w_ld_m = 1'b1;
          end else if (w_out_xfer) begin
            w_nstate = EMPTY;
          end else if (w_in_xfer) begin
            w_ld_s   = 1'b1;
            w_nstate = TWO;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            w_m_from_s = 1'b1;
            w_nstate   = ONE;
          end
        end
        default: begin
          w_nstate = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_data <= '0;
      r_m_sel  <= '0;
      r_s_data <= '0;
      r_s_sel  <= '0;
    end else begin
      if (w_ld_m) begin
        r_m_data <= w_word;
        r_m_sel  <= in_sel;
      end else if (w_m_from_s) begin
        r_m_data <= r_s_data;
        r_m_sel  <= r_s_sel;
      end
      if (w_ld_s) begin
        r_s_data <= w_word;
        r_s_sel  <= in_sel;
      end
    end
  end

`ifdef PIPE_MUX_SELERR_EN
  logic w_err;
  logic r_m_err;
  logic r_s_err;

  always_comb begin
    w_err = 1'b1;
    for (int k = 0; k < NSRC; k++) begin
      if (in_sel == SELW'(k)) begin
        w_err = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_err <= 1'b0;
      r_s_err <= 1'b0;
    end else if (flush) begin
      r_m_err <= 1'b0;
      r_s_err <= 1'b0;
    end else begin
      if (w_ld_m) begin
        r_m_err <= w_err;
      end else if (w_m_from_s) begin
        r_m_err <= r_s_err;
      end
      if (w_ld_s) begin
        r_s_err <= w_err;
      end
    end
  end

  // stale flag after draining must not leak out
  assign sel_err = r_m_err & w_out_valid;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_m_data;
  assign out_sel   = r_m_sel;
  assign occupancy = r_state;

endmodule

// File: tb/tb_pipe_mux_n.sv
// tb_pipe_mux_n: directed checks of pipe_mux_n, one NSRC=4
// and one NSRC=3 instance driven with the same handshakes.
module tb_pipe_mux_n;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [127:0] in_data;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;

  logic         a_in_ready, a_out_valid;
  logic [31:0]  a_out_data;
  logic [1:0]   a_out_sel, a_occ;
  logic         b_in_ready, b_out_valid;
  logic [31:0]  b_out_data;
  logic [1:0]   b_out_sel, b_occ;
`ifdef PIPE_MUX_SELERR_EN
  logic         a_err, b_err;
`endif

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] src [4];

  always #5 clk = ~clk;

  pipe_mux_n #(.WIDTH(32), .NSRC(4), .SELW(2)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .out_data(a_out_data), .out_sel(a_out_sel),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .occupancy(a_occ)
`ifdef PIPE_MUX_SELERR_EN
    , .sel_err(a_err)
`endif
  );

  pipe_mux_n #(.WIDTH(32), .NSRC(3), .SELW(2)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data[95:0]), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_sel(b_out_sel),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .occupancy(b_occ)
`ifdef PIPE_MUX_SELERR_EN
    , .sel_err(b_err)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    src[0] = 32'h11111111;
    src[1] = 32'h22222222;
    src[2] = 32'h33333333;
    src[3] = 32'h44444444;
    in_data = {src[3], src[2], src[1], src[0]};

    #2;
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_data", 64'(a_out_data), 64'd0);
    chk("rst_sel", 64'(a_out_sel), 64'd0);
    chk("rst_occ", 64'(a_occ), 64'd0);
    chk("rst_ready", 64'(a_in_ready), 64'd1);
`ifdef PIPE_MUX_SELERR_EN
    chk("rst_err", 64'(a_err), 64'd0);
`endif
    step();
    step();
    rst = 1'b0;

    // single beat
    in_sel = 2'd2;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    chk("one_data", 64'(a_out_data), 64'h33333333);
    chk("one_sel", 64'(a_out_sel), 64'd2);
    chk("one_valid", 64'(a_out_valid), 64'd1);
    chk("one_occ", 64'(a_occ), 64'd1);
    in_valid = 1'b0;
    step();
    chk("one_drain", 64'(a_out_valid), 64'd0);

    // back-to-back, sel 0..3
    for (int i = 0; i < 4; i++) begin
      in_sel = 2'(i);
      in_valid = 1'b1;
      step();
      chk("b2b_data", 64'(a_out_data), 64'(src[i]));
      chk("b2b_ready", 64'(a_in_ready), 64'd1);
      chk("b2b_occ", 64'(a_occ), 64'd1);
      if (i < 3) begin
        chk("b2b_n3", 64'(b_out_data), 64'(src[i]));
      end else begin
        chk("oor_n3", 64'(b_out_data), 64'd0);
      end
`ifdef PIPE_MUX_SELERR_EN
      chk("err_a", 64'(a_err), 64'd0);
      chk("err_b", 64'(b_err), (i == 3) ? 64'd1 : 64'd0);
`endif
    end
    in_sel = 2'd1;
    step();
    chk("after_oor", 64'(b_out_data), 64'h22222222);
`ifdef PIPE_MUX_SELERR_EN
    chk("after_err", 64'(b_err), 64'd0);
`endif
    in_valid = 1'b0;
    step();
    chk("b2b_end", 64'(a_occ), 64'd0);

    // stall: three beats offered, two taken
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 2'd0;
    step();
    chk("st1_occ", 64'(a_occ), 64'd1);
    chk("st1_ready", 64'(a_in_ready), 64'd1);
    in_sel = 2'd1;
    step();
    chk("st2_occ", 64'(a_occ), 64'd2);
    chk("st2_ready", 64'(a_in_ready), 64'd0);
    chk("st2_data", 64'(a_out_data), 64'h11111111);
    in_sel = 2'd2;
    step();
    chk("st3_occ", 64'(a_occ), 64'd2);
    chk("st3_data", 64'(a_out_data), 64'h11111111);
    out_ready = 1'b1;
    step();
    chk("dr1_data", 64'(a_out_data), 64'h22222222);
    chk("dr1_occ", 64'(a_occ), 64'd1);
    chk("dr1_ready", 64'(a_in_ready), 64'd1);
    step();
    chk("dr2_data", 64'(a_out_data), 64'h33333333);
    chk("dr2_occ", 64'(a_occ), 64'd1);
    in_valid = 1'b0;
    step();
    chk("dr3_valid", 64'(a_out_valid), 64'd0);
    chk("dr3_occ", 64'(a_occ), 64'd0);

    // flush while full with a beat offered
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 2'd0;
    step();
    in_sel = 2'd1;
    step();
    chk("fl_pre", 64'(a_occ), 64'd2);
    flush = 1'b1;
    in_sel = 2'd3;
    step();
    chk("fl_valid", 64'(a_out_valid), 64'd0);
    chk("fl_occ", 64'(a_occ), 64'd0);
    chk("fl_ready", 64'(a_in_ready), 64'd1);
    chk("fl_stale", 64'(a_out_data), 64'h11111111);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_none", 64'(a_out_valid), 64'd0);

    // flush in ONE with an input handshake offered
    in_valid = 1'b1;
    in_sel = 2'd2;
    step();
    flush = 1'b1;
    in_sel = 2'd3;
    step();
    chk("fl1_valid", 64'(a_out_valid), 64'd0);
    chk("fl1_occ", 64'(a_occ), 64'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("fl1_none", 64'(a_out_valid), 64'd0);

    // async reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_sel = 2'd2;
    step();
    in_sel = 2'd3;
    step();
    chk("ar_pre", 64'(a_occ), 64'd2);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 64'(a_out_valid), 64'd0);
    chk("ar_occ", 64'(a_occ), 64'd0);
    chk("ar_ready", 64'(a_in_ready), 64'd1);
    chk("ar_data", 64'(a_out_data), 64'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    step();
    chk("ar_post", 64'(a_out_valid), 64'd0);
    chk("ar_post_occ", 64'(a_occ), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_mux_n.md
# pipe_mux_n

Parametrised N-way operand select with a registered, flow-controlled output stage for the pipelined CPU datapath. Each accepted beat carries NSRC packed candidate words and a select code. The chosen word is captured into a two-entry skid buffer, so a stalled consumer never combinationally back-pressures the producer. It replaces fixed-width, fixed-fan-in combinational selects wherever a stage boundary with stall and flush support sits behind the select.

## Interface
- WIDTH, 32, bits per data word.
- NSRC, 4, number of candidate sources (≥2).
- SELW, 2, select width; 2**SELW ≥ NSRC is required and checked at elaboration.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all buffered beats.
- in_data  in  NSRC*WIDTH  candidates; source k at [k*WIDTH +: WIDTH].
- in_sel  in  SELW  source index for this beat.
- in_valid  in  1  producer has a beat.
- in_ready  out  1  buffer can accept; registered, equals "skid entry empty".
- out_data  out  WIDTH  selected word, registered.
- out_sel  out  SELW  select code captured with out_data.
- out_valid  out  1  out_data holds a beat.
- out_ready  in  1  consumer takes beat.
- occupancy  out  2  beats held (0, 1, 2).
- sel_err  out  1  only with PIPE_MUX_SELERR_EN; see Configuration.

## Operation
- Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
- The select is resolved at input time: word = source in_sel if in_sel < NSRC, else all-zero.
- Storage: main register M (drives the out_* ports) and skid register S.
- States: EMPTY (occupancy 0), ONE (occupancy 1), TWO (occupancy 2).
- EMPTY: input transfer → load M, go to ONE.
- ONE, output transfer and input transfer → reload M, stay in ONE.
- ONE, output transfer only → go to EMPTY.
- ONE, input transfer while out_ready=0 → load S, go to TWO.
- ONE, neither transfer → hold.
- TWO: in_ready=0. On an output transfer, M←S and go to ONE; otherwise hold.
- Order is strict FIFO. No beat is duplicated or dropped except by flush or rst.
- flush has priority over both transfers. Next state is EMPTY and out_valid=0. Any input handshake in the flush cycle is discarded. out_data and out_sel keep their stale values.
- Reset values: out_valid=0, out_data=0, out_sel=0, occupancy=0, sel_err=0. in_ready=1 from reset assertion onward.

## Timing
- Latency is 1 cycle: a beat accepted on edge n appears on out_data after edge n. There is no combinational path from in_* to out_*.
- in_ready depends only on registered state; there is no out_ready→in_ready combinational path.
- in_ready deasserts on the edge after the beat that fills S. It reasserts on the edge after the output transfer that drains S.
- Sustained throughput is one beat per cycle while out_ready=1.
- If rst asserts mid-operation, all state clears immediately. Beats in flight are lost and the first edge after release sees EMPTY.

## Configuration
- Macro: PIPE_MUX_SELERR_EN.
- Defined:
  - The sel_err port exists. It is stored per beat in both M and S and presented with out_valid.
  - sel_err=1 exactly when the beat's in_sel ≥ NSRC.
  - flush and rst clear it.
- Undefined:
  - The port is absent.
  - Out-of-range selects still yield out_data=0, with no indication.

## Test plan
- Reset, then WIDTH=32 and NSRC=4 with sources 0x11111111/0x22222222/0x33333333/0x44444444, in_sel=2, out_ready=1 → next cycle out_data=0x33333333, out_sel=2, out_valid=1, occupancy=1.
- Back-to-back beats with sel=0,1,2,3 and out_ready=1 → four consecutive outputs in that order, one per cycle, with in_ready held at 1.
- out_ready=0 with three beats offered → first two accepted, in_ready=0 after the second, occupancy=2. Raise out_ready → outputs appear in order, the third beat is accepted once in_ready returns to 1, and nothing is lost.
- flush while occupancy=2 and an input beat is offered → next cycle out_valid=0, occupancy=0, in_ready=1, and the offered beat never appears.
- NSRC=3 and in_sel=3 → out_data=0. With the macro, sel_err=1 for that beat only; the next beat with in_sel=1 gives sel_err=0.
- rst pulse asserted between clock edges while occupancy=2 → out_valid=0 and occupancy=0 immediately, with no beat emitted after release.
